gray_sobel_src_ctrl: RTL and testbench

Pixel-source sequencer for the gray/sobel datapath. Selects SPI-received pixels or LFSR-generated test pixels and feeds them to `top_gray_sobel` with a one-cycle `px_rdy` strobe. Limits in-flight pixels with a credit counter and tracks returned results to signal frame completion. Also loads the 16-bit LFSR seed and stop code from a byte port.

---
 rtl/gray_sobel_src_ctrl_pkg.sv | 20 ++
 rtl/gray_sobel_src_ctrl_cfg_loader.sv | 47 ++++
 rtl/gray_sobel_src_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_gray_sobel_src_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_sobel_src_ctrl_pkg.sv
// Shared definitions for the gray/sobel pixel-source sequencer:
// pixel width, sequencer state encoding and source-select codes.
package gray_sobel_src_ctrl_pkg;

  localparam int MAX_PIXEL_BITS = 8;

  // Number of configuration bytes: seed hi/lo, stop hi/lo.
  localparam int CFG_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } src_ctrl_state_t;

  localparam logic SRC_SPI  = 1'b0;
  localparam logic SRC_LFSR = 1'b1;

endpackage

// File: rtl/gray_sobel_src_ctrl_cfg_loader.sv
// Byte-serial loader for the 16-bit LFSR seed and stop code.
// Byte order: seed[15:8], seed[7:0], stop[15:8], stop[7:0]; a further
// byte restarts the sequence and clears the loaded flag.
module gray_sobel_src_ctrl_cfg_loader
  import gray_sobel_src_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  cfg_byte_i,
  input  logic        cfg_valid_i,
  input  logic        lock_i,
  output logic [15:0] seed_o,
  output logic [15:0] stop_o,
  output logic        loaded_o
);

  localparam int IDX_W = $clog2(CFG_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CFG_BYTES - 1);

  logic [IDX_W-1:0] idx_reg;
  logic [7:0]       byte_reg [CFG_BYTES];
  logic             loaded_reg;
  logic             accept;

  // Bytes are refused while an LFSR frame is using the seed/stop values.
  assign accept = cfg_valid_i && !lock_i;

  // Store each accepted byte at the current index; the index wraps after the last byte.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_reg    <= '0;
      loaded_reg <= 1'b0;
      for (int i = 0; i < CFG_BYTES; i++) begin
        byte_reg[i] <= '0;
      end
    end else if (accept) begin
      byte_reg[idx_reg] <= cfg_byte_i;
      idx_reg           <= idx_reg + 1'b1;
      loaded_reg        <= (idx_reg == IDX_LAST);
    end
  end

  assign seed_o   = {byte_reg[0], byte_reg[1]};
  assign stop_o   = {byte_reg[2], byte_reg[3]};
  assign loaded_o = loaded_reg;

endmodule

// File: rtl/gray_sobel_src_ctrl.sv
// Pixel-source sequencer for the gray/sobel datapath. Issues SPI or LFSR
// pixels with a registered one-cycle strobe, limits in-flight pixels with a
// credit counter and signals frame completion once all results return.
// Optional macro SRC_CTRL_DRAIN_WDT_EN adds a DRAIN watchdog that abandons
// the frame with an error pulse after DRAIN_TIMEOUT cycles.
module gray_sobel_src_ctrl
  import gray_sobel_src_ctrl_pkg::*;
#(
  parameter int PX_W          = MAX_PIXEL_BITS,
  parameter int FRAME_PX      = 64,
  parameter int MAX_OUT       = 4,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            src_sel_i,
  input  logic [7:0]      cfg_byte_i,
  input  logic            cfg_valid_i,
  input  logic [PX_W-1:0] spi_px_i,
  input  logic            spi_px_rdy_i,
  input  logic [PX_W-1:0] lfsr_px_i,
  input  logic            lfsr_done_i,
  input  logic            res_rdy_i,
  output logic [PX_W-1:0] px_o,
  output logic            px_rdy_o,
  output logic            lfsr_step_o,
  output logic [15:0]     lfsr_seed_o,
  output logic [15:0]     lfsr_stop_o,
  output logic            cfg_loaded_o,
  output logic            busy_o,
  output logic            frame_done_o,
  output logic            err_o,
  output logic            ovf_o
);

  localparam int CNT_W = $clog2(FRAME_PX + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] FRAME_PRE = CNT_W'(FRAME_PX - 1);
  localparam logic [OUT_W-1:0] OUT_LIMIT = OUT_W'(MAX_OUT);

  src_ctrl_state_t  state_reg, state_next;
  logic             src_reg;
  logic [CNT_W-1:0] issued_reg;
  logic [OUT_W-1:0] out_reg, out_next;
  logic             ovf_reg, err_reg, px_rdy_reg;
  logic [PX_W-1:0]  px_reg;

  logic cfg_loaded;
  logic start_ok, start_err;
  logic issue_spi, issue_lfsr, issue, drop;
  logic res_take, last_issue, abort_now, wdt_expire;

  gray_sobel_src_ctrl_cfg_loader u_cfg (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .cfg_byte_i (cfg_byte_i),
    .cfg_valid_i(cfg_valid_i),
    .lock_i     ((state_reg != IDLE) && (src_reg == SRC_LFSR)),
    .seed_o     (lfsr_seed_o),
    .stop_o     (lfsr_stop_o),
    .loaded_o   (cfg_loaded)
  );

  assign abort_now  = abort_i && (state_reg != IDLE);
  assign issue      = issue_spi || issue_lfsr;
  assign res_take   = res_rdy_i && (out_reg != '0);
  assign last_issue = (issue && (issued_reg == FRAME_PRE)) || (issue_lfsr && lfsr_done_i);

  // Outstanding credit count: an issue and a result in the same cycle cancel.
  always_comb begin
    out_next = out_reg;
    if (issue && !res_take) begin
      out_next = out_reg + 1'b1;
    end else if (!issue && res_take) begin
      out_next = out_reg - 1'b1;
    end
  end

`ifdef SRC_CTRL_DRAIN_WDT_EN
  localparam int WDT_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(DRAIN_TIMEOUT - 1);
  logic [WDT_W-1:0] wdt_reg;

  // Count cycles spent in DRAIN; leaving DRAIN restarts the count.
  always_ff @(posedge clk_i) begin
    if (reset_i || (state_reg != DRAIN)) begin
      wdt_reg <= '0;
    end else begin
      wdt_reg <= wdt_reg + 1'b1;
    end
  end

  assign wdt_expire = (state_reg == DRAIN) && !abort_i && (out_next != '0) && (wdt_reg == WDT_LAST);
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = DRAIN_TIMEOUT;
  assign wdt_expire     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    state_next = state_reg;
    if (abort_now) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start_ok) state_next = RUN;
        RUN:     if (last_issue) state_next = DRAIN;
        DRAIN: begin
          if (out_next == '0) begin
            state_next = DONE;
          end else if (wdt_expire) begin
            state_next = IDLE;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Per-state decisions: start handling, issue/drop, and state-decoded outputs.
  always_comb begin
    start_ok     = 1'b0;
    start_err    = 1'b0;
    issue_spi    = 1'b0;
    issue_lfsr   = 1'b0;
    drop         = 1'b0;
    busy_o       = (state_reg != IDLE);
    frame_done_o = (state_reg == DONE);
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          if ((src_sel_i == SRC_LFSR) && !cfg_loaded) begin
            start_err = 1'b1;
          end else begin
            start_ok = 1'b1;
          end
        end
      end
      RUN: begin
        if (!abort_i) begin
          if (src_reg == SRC_LFSR) begin
            issue_lfsr = (out_reg < OUT_LIMIT);
          end else if (spi_px_rdy_i) begin
            if (out_reg < OUT_LIMIT) begin
              issue_spi = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    lfsr_step_o = issue_lfsr && !reset_i;
  end

  // Frame counters, sticky overflow, registered pixel strobe and error pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      src_reg    <= SRC_SPI;
      issued_reg <= '0;
      out_reg    <= '0;
      ovf_reg    <= 1'b0;
      err_reg    <= 1'b0;
      px_rdy_reg <= 1'b0;
      px_reg     <= '0;
    end else begin
      px_rdy_reg <= issue;
      err_reg    <= start_err || wdt_expire;
      if (issue_spi) begin
        px_reg <= spi_px_i;
      end else if (issue_lfsr) begin
        px_reg <= lfsr_px_i;
      end
      if (start_ok) begin
        src_reg    <= src_sel_i;
        issued_reg <= '0;
        out_reg    <= '0;
        ovf_reg    <= 1'b0;
      end else if (abort_now || wdt_expire) begin
        issued_reg <= '0;
        out_reg    <= '0;
      end else begin
        if (issue) begin
          issued_reg <= issued_reg + 1'b1;
        end
        out_reg <= out_next;
        if (drop) begin
          ovf_reg <= 1'b1;
        end
      end
    end
  end

  assign px_o         = px_reg;
  assign px_rdy_o     = px_rdy_reg;
  assign cfg_loaded_o = cfg_loaded;
  assign err_o        = err_reg;
  assign ovf_o        = ovf_reg;

endmodule

// File: tb/tb_gray_sobel_src_ctrl.sv
// Self-checking bench for gray_sobel_src_ctrl: config loading, start error,
// SPI frames (fixed and randomized spacing), credit overflow, abort, LFSR
// frame, and the DRAIN watchdog when SRC_CTRL_DRAIN_WDT_EN is defined.
module tb_gray_sobel_src_ctrl;
  import gray_sobel_src_ctrl_pkg::*;

  localparam int PX_W          = MAX_PIXEL_BITS;
  localparam int FRAME_PX      = 6;
  localparam int MAX_OUT       = 2;
  localparam int DRAIN_TIMEOUT = 20;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0, abort = 1'b0, src_sel = 1'b0;
  logic [7:0]      cfg_byte = '0;
  logic            cfg_valid = 1'b0;
  logic [PX_W-1:0] spi_px = '0;
  logic            spi_px_rdy = 1'b0;
  logic [PX_W-1:0] lfsr_px = '0;
  logic            lfsr_done = 1'b0;
  logic            res_rdy = 1'b0;
  logic [PX_W-1:0] px_o;
  logic            px_rdy_o, lfsr_step_o, cfg_loaded_o, busy_o, frame_done_o, err_o, ovf_o;
  logic [15:0]     lfsr_seed_o, lfsr_stop_o;

  gray_sobel_src_ctrl #(
    .PX_W(PX_W), .FRAME_PX(FRAME_PX), .MAX_OUT(MAX_OUT), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort), .src_sel_i(src_sel),
    .cfg_byte_i(cfg_byte), .cfg_valid_i(cfg_valid), .spi_px_i(spi_px), .spi_px_rdy_i(spi_px_rdy),
    .lfsr_px_i(lfsr_px), .lfsr_done_i(lfsr_done), .res_rdy_i(res_rdy),
    .px_o(px_o), .px_rdy_o(px_rdy_o), .lfsr_step_o(lfsr_step_o),
    .lfsr_seed_o(lfsr_seed_o), .lfsr_stop_o(lfsr_stop_o), .cfg_loaded_o(cfg_loaded_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation scoreboard, sampled mid-cycle.
  logic [PX_W-1:0] got_q[$];
  int res_due[$];
  int res_lat = 3;
  bit res_en = 1'b0;
  int n_step = 0, n_done = 0, n_err = 0;
  int done_cyc = -1, err_cyc = -1, last_res_cyc = -1;

  always @(negedge clk) begin
    if (px_rdy_o) begin
      got_q.push_back(px_o);
      if (res_en) res_due.push_back(cyc + res_lat);
    end
    if (lfsr_step_o) n_step++;
    if (frame_done_o) begin n_done++; done_cyc = cyc; end
    if (err_o) begin n_err++; err_cyc = cyc; end
    if (res_rdy) last_res_cyc = cyc;
  end

  // Model of the datapath: one result per issued pixel, res_lat cycles later.
  always @(posedge clk) begin
    #1;
    res_rdy = 1'b0;
    if (res_due.size() > 0 && res_due[0] == cyc) begin
      res_rdy = 1'b1;
      void'(res_due.pop_front());
    end
  end

  // Model of the LFSR block: presents lfsr_vals[k] after k steps, done at index lfsr_last.
  logic [PX_W-1:0] lfsr_vals [8];
  int lfsr_base = 0;
  int lfsr_last = 0;
  always @(posedge clk) begin
    int k;
    #1;
    k = n_step - lfsr_base;
    lfsr_px   = lfsr_vals[k % 8];
    lfsr_done = (k >= lfsr_last);
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // which: 0 = frame_done count, 1 = err count.
  task automatic wait_count(input int which, input int prev, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      samp();
      if ((which == 0 && n_done > prev) || (which == 1 && n_err > prev)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_pixels(input string tag, input logic [PX_W-1:0] exp_q[$]);
    logic [31:0] o;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) o = 32'(got_q[i]);
      else o = 'x;
      chk($sformatf("%s_px%0d", tag, i), o, 32'(exp_q[i]));
    end
  endtask

  initial begin
    logic [PX_W-1:0] exp_q[$];
    logic [7:0] cfg_vals [4];
    logic [7:0] r1, r2, r3;
    int issued_cyc[$];
    int done0, err0, step0, start_cyc, n_issued, returned;
    bit ok, drop_any;

    for (int i = 0; i < 8; i++) lfsr_vals[i] = '0;

    // ---- reset state ----
    repeat (3) tick();
    samp();
    chk("rst_px_rdy", px_rdy_o, 0);
    chk("rst_px", px_o, 0);
    chk("rst_lfsr_step", lfsr_step_o, 0);
    chk("rst_seed", lfsr_seed_o, 0);
    chk("rst_stop", lfsr_stop_o, 0);
    chk("rst_loaded", cfg_loaded_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", frame_done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ovf", ovf_o, 0);
    tick();
    reset = 1'b0;

    // ---- LFSR start without config -> error, stays idle ----
    tick();
    start = 1'b1; src_sel = 1'b1;
    tick();
    start = 1'b0; src_sel = 1'b0;
    samp();
    chk("cfgless_err", err_o, 1);
    chk("cfgless_busy", busy_o, 0);
    tick();
    samp();
    chk("cfgless_err_pulse", err_o, 0);
    chk("cfgless_busy_after", busy_o, 0);
    $display("txn start_without_cfg: err pulses=%0d", n_err);

    // ---- config load ----
    cfg_vals = '{8'hAC, 8'hE1, 8'h00, 8'h10};
    for (int i = 0; i < 4; i++) begin
      tick();
      cfg_valid = 1'b1; cfg_byte = cfg_vals[i];
    end
    tick();
    cfg_valid = 1'b0;
    samp();
    chk("cfg_seed", lfsr_seed_o, 16'hACE1);
    chk("cfg_stop", lfsr_stop_o, 16'h0010);
    chk("cfg_loaded", cfg_loaded_o, 1);
    tick();
    cfg_valid = 1'b1; cfg_byte = 8'h12;
    tick();
    cfg_valid = 1'b0;
    samp();
    chk("cfg5_loaded", cfg_loaded_o, 0);
    chk("cfg5_seed", lfsr_seed_o, 16'h12E1);
    chk("cfg5_stop", lfsr_stop_o, 16'h0010);
    $display("txn cfg_load: seed=%h stop=%h loaded=%0d", lfsr_seed_o, lfsr_stop_o, cfg_loaded_o);

    // ---- SPI frame, strobes every 3 cycles, results 3 cycles later ----
    tick();
    res_en = 1'b1; res_lat = 3;
    got_q.delete(); exp_q.delete();
    done0 = n_done;
    start = 1'b1; src_sel = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < FRAME_PX; i++) begin
      spi_px = PX_W'($urandom);
      exp_q.push_back(spi_px);
      spi_px_rdy = 1'b1;
      tick();
      spi_px_rdy = 1'b0;
      tick();
      tick();
    end
    spi_px = PX_W'($urandom);
    spi_px_rdy = 1'b1;   // arrives in DRAIN, must be ignored
    tick();
    spi_px_rdy = 1'b0;
    wait_count(0, done0, 60, ok);
    chk("spi_done_seen", ok, 1);
    chk("spi_done_timing", done_cyc, last_res_cyc + 1);
    chk("spi_busy_in_done", busy_o, 1);
    samp();
    chk("spi_busy_after", busy_o, 0);
    chk("spi_done_pulse", frame_done_o, 0);
    chk("spi_done_once", n_done, done0 + 1);
    chk("spi_ovf", ovf_o, 0);
    chk("spi_px_hold", px_o, exp_q[exp_q.size() - 1]);
    chk_pixels("spi", exp_q);
    $display("txn spi_frame: issued=%0d done_cyc=%0d", got_q.size(), done_cyc);

    // ---- credit overflow, then abort with 2 outstanding ----
    tick();
    res_en = 1'b0;
    got_q.delete(); exp_q.delete();
    done0 = n_done;
    start = 1'b1; src_sel = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      spi_px = PX_W'($urandom);
      if (i < MAX_OUT) exp_q.push_back(spi_px);
      spi_px_rdy = 1'b1;
      tick();
    end
    spi_px_rdy = 1'b0;
    tick();
    samp();
    chk("ovf_flag", ovf_o, 1);
    chk("ovf_busy", busy_o, 1);
    chk_pixels("ovf", exp_q);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    samp();
    chk("abort_busy", busy_o, 0);
    chk("abort_ovf_sticky", ovf_o, 1);
    repeat (4) tick();
    chk("abort_no_done", n_done, done0);
    $display("txn overflow_abort: issued=%0d ovf=%0d", got_q.size(), ovf_o);

    // ---- reload remaining config bytes (index continues after the 5th byte) ----
    r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
    cfg_vals = '{r1, r2, r3, 8'h00};
    for (int i = 0; i < 3; i++) begin
      tick();
      cfg_valid = 1'b1; cfg_byte = cfg_vals[i];
    end
    tick();
    cfg_valid = 1'b0;
    samp();
    chk("reload_seed", lfsr_seed_o, {8'h12, r1});
    chk("reload_stop", lfsr_stop_o, {r2, r3});
    chk("reload_loaded", cfg_loaded_o, 1);

    // ---- LFSR frame: final pixel at the 5th issue, results 1 cycle later ----
    tick();
    for (int i = 0; i < 8; i++) lfsr_vals[i] = PX_W'($urandom);
    lfsr_base = n_step; lfsr_last = 4;
    res_en = 1'b1; res_lat = 1;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(lfsr_vals[i]);
    done0 = n_done; step0 = n_step;
    tick();
    start = 1'b1; src_sel = 1'b1;
    tick();
    start = 1'b0; src_sel = 1'b0;
    cfg_valid = 1'b1; cfg_byte = ~r1;   // locked out during the LFSR frame
    samp();
    chk("lfsr_ovf_cleared", ovf_o, 0);
    tick();
    cfg_valid = 1'b0;
    wait_count(0, done0, 60, ok);
    chk("lfsr_done_seen", ok, 1);
    chk("lfsr_done_timing", done_cyc, last_res_cyc + 1);
    chk("lfsr_steps", n_step - step0, 5);
    chk_pixels("lfsr", exp_q);
    chk("lfsr_seed_locked", lfsr_seed_o, {8'h12, r1});
    chk("lfsr_loaded_kept", cfg_loaded_o, 1);
    $display("txn lfsr_frame: steps=%0d done_cyc=%0d", n_step - step0, done_cyc);
    samp();

`ifdef SRC_CTRL_DRAIN_WDT_EN
    // ---- DRAIN watchdog: single final pixel whose result never returns ----
    tick();
    res_en = 1'b0;
    lfsr_base = n_step; lfsr_last = 0;
    done0 = n_done; err0 = n_err;
    tick();
    start = 1'b1; src_sel = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0; src_sel = 1'b0;
    wait_count(1, err0, DRAIN_TIMEOUT + 20, ok);
    chk("wdt_err_seen", ok, 1);
    chk("wdt_err_timing", err_cyc, start_cyc + 2 + DRAIN_TIMEOUT);
    chk("wdt_busy", busy_o, 0);
    chk("wdt_no_done", n_done, done0);
    $display("txn drain_watchdog: err_cyc=%0d", err_cyc);
    samp();
`endif

    // ---- randomized SPI frame against a credit model ----
    tick();
    res_en = 1'b1; res_lat = int'($urandom_range(1, 3));
    got_q.delete(); exp_q.delete(); issued_cyc.delete();
    done0 = n_done; n_issued = 0; drop_any = 1'b0;
    start = 1'b1; src_sel = 1'b0;
    tick();
    start = 1'b0;
    for (int it = 0; it < 400 && n_issued < FRAME_PX; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        returned = 0;
        foreach (issued_cyc[j]) if (issued_cyc[j] + 1 + res_lat < cyc) returned++;
        spi_px = PX_W'($urandom);
        if (n_issued - returned < MAX_OUT) begin
          exp_q.push_back(spi_px);
          issued_cyc.push_back(cyc);
          n_issued++;
        end else begin
          drop_any = 1'b1;
        end
        spi_px_rdy = 1'b1;
      end else begin
        spi_px_rdy = 1'b0;
      end
      tick();
    end
    spi_px_rdy = 1'b0;
    chk("rnd_issue_budget", n_issued, FRAME_PX);
    wait_count(0, done0, 60, ok);
    chk("rnd_done_seen", ok, 1);
    chk("rnd_done_timing", done_cyc, last_res_cyc + 1);
    chk("rnd_ovf", ovf_o, drop_any);
    chk_pixels("rnd", exp_q);
    $display("txn rnd_spi_frame: lat=%0d issued=%0d dropped_any=%0d", res_lat, got_q.size(), drop_any);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
